// File: rtl/simplerv_pkg.sv
// simplerv_pkg: shared loader state encoding and stream framing constants.
package simplerv_pkg;
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_CHK, S_DONE, S_ERR} load_state_t;
    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs a little-endian byte stream into 32-bit words.
module word_assembler
    import simplerv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] lo;
    assign word_valid = take && cnt == 2'(BYTES_PER_WORD - 1);
    // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
    assign word = {data, lo};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            lo  <= '0;
        end else if (clr) begin
            cnt <= '0;
            lo  <= '0;
        end else if (take) begin
            cnt <= cnt + 2'd1;
            lo  <= {data, lo[23:8]};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory, holding the CPU until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import simplerv_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam load_state_t S_FIN = S_CHK;
    logic [7:0] csum;
`else
    localparam load_state_t S_FIN = S_DONE;
`endif
    load_state_t         state, state_nxt;
    logic                take, word_valid;
    logic [31:0]         word;
    logic [ADDR_WIDTH:0] n, wl_inc;

    assign in_ready = state inside {S_HDR, S_LOAD, S_CHK};
    assign cpu_hold = state != S_DONE;
    assign done     = state == S_DONE;
    assign err      = state == S_ERR;
    // A byte arriving with reload is dropped.
    assign take     = in_valid && in_ready && !reload;
    assign wl_inc   = words_loaded + 1'b1;

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (reload),
        .take       (take && (state == S_HDR || state == S_LOAD)),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (reload) state_nxt = S_HDR;
        else case (state)
            S_HDR:  if (word_valid) state_nxt = word == 32'd0 ? S_FIN : ({1'b0, word} > CAP ? S_ERR : S_LOAD);
            S_LOAD: if (word_valid && wl_inc == n) state_nxt = S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:  if (take) state_nxt = in_data == csum ? S_DONE : S_ERR;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            n            <= '0;
        end else begin
            mem_we <= 1'b0;
            if (reload) begin
                words_loaded <= '0;
                n            <= '0;
            end else if (word_valid && state == S_HDR) begin
                // Oversized counts go to ERR, so truncation here is harmless.
                n <= word[ADDR_WIDTH:0];
            end else if (word_valid && state == S_LOAD) begin
                mem_we       <= 1'b1;
                mem_addr     <= 32'({words_loaded[ADDR_WIDTH-1:0], 2'b00});
                mem_wdata    <= word;
                words_loaded <= wl_inc;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          csum <= '0;
        else if (reload)                  csum <= '0;
        else if (take && state == S_LOAD) csum <= csum ^ in_data;
    end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (honours IMEM_LOADER_CHECKSUM_EN).
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        cpu_hold, done, err;
    logic [12:0] words_loaded;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    imem_loader #(.ADDR_WIDTH(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        wr_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk) #1;
        reload = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    initial begin
        int bad;
        idle(3);
        check("rst_in_ready", in_ready, 1);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_words", words_loaded, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;
        idle(1);

        // 1: two-word image
        send_word(32'd2);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_hold_in_chk", cpu_hold, 1);
        send(8'h90);
`endif
        idle(2);
        check("t1_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("t1_addr0", wr_addr[0], 32'h0);
            check("t1_data0", wr_data[0], 32'h00000013);
            check("t1_addr1", wr_addr[1], 32'h4);
            check("t1_data1", wr_data[1], 32'h00100093);
        end
        check("t1_done", done, 1);
        check("t1_cpu_hold", cpu_hold, 0);
        check("t1_in_ready", in_ready, 0);
        check("t1_words", words_loaded, 2);
        check("t1_addr_hold", mem_addr, 32'h4);
        check("t1_data_hold", mem_wdata, 32'h00100093);
        send_word(32'hFFFFFFFF);
        idle(2);
        check("t1_ignored", wr_addr.size(), 2);

        do_reload();
        check("rl_done", done, 0);
        check("rl_cpu_hold", cpu_hold, 1);
        check("rl_in_ready", in_ready, 1);
        check("rl_words", words_loaded, 0);

        // 2: empty image
        send_word(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        idle(1);
        check("t2_wait_chk", done, 0);
        send(8'h00);
`endif
        idle(1);
        check("t2_done", done, 1);
        check("t2_nwrites", wr_addr.size(), 0);
        check("t2_words", words_loaded, 0);

        // 3: oversized count
        do_reload();
        send_word(32'h1001);
        idle(1);
        check("t3_err", err, 1);
        check("t3_in_ready", in_ready, 0);
        check("t3_cpu_hold", cpu_hold, 1);
        send_word(32'h12345678);
        idle(2);
        check("t3_nwrites", wr_addr.size(), 0);

        // 4: gap mid-word, then a full-rate burst
        do_reload();
        check("t4_err_cleared", err, 0);
        send_word(32'd3);
        send(8'h44); send(8'h33);
        idle(10);
        check("t4_no_early", wr_addr.size(), 0);
        send(8'h22); send(8'h11);
        send_word(32'hA5A5A5A5);
        send_word(32'h0F0F0F0F);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h44);
`endif
        idle(2);
        check("t4_nwrites", wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            check("t4_data0", wr_data[0], 32'h11223344);
            check("t4_data1", wr_data[1], 32'hA5A5A5A5);
            check("t4_addr2", wr_addr[2], 32'h8);
            check("t4_data2", wr_data[2], 32'h0F0F0F0F);
            check("t4_spacing", wr_cyc[2] - wr_cyc[1], 4);
        end
        check("t4_done", done, 1);

        // 5: async reset mid-word
        do_reload();
        send_word(32'd1);
        send(8'hAA); send(8'hBB);
        rst = 1'b1;
        #2;
        check("t5_in_ready", in_ready, 1);
        check("t5_cpu_hold", cpu_hold, 1);
        check("t5_words", words_loaded, 0);
        check("t5_addr", mem_addr, 0);
        idle(2);
        rst = 1'b0;
        idle(1);
        check("t5_nwrites_rst", wr_addr.size(), 0);
        send_word(32'd1);
        send_word(32'hCAFEF00D);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hC9);
`endif
        idle(2);
        check("t5_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("t5_addr0", wr_addr[0], 32'h0);
            check("t5_data0", wr_data[0], 32'hCAFEF00D);
        end
        check("t5_done", done, 1);

        // full capacity: last write lands on the top word
        do_reload();
        send_word(32'h1000);
        for (int i = 0; i < 4096; i++) send_word(32'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        idle(2);
        check("cap_nwrites", wr_addr.size(), 4096);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== 32'(i)) bad++;
        check("cap_bad_entries", bad, 0);
        check("cap_addr_top", mem_addr, 32'h3FFC);
        check("cap_words", words_loaded, 13'h1000);
        check("cap_done", done, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum good and bad
        do_reload();
        send_word(32'd1);
        send_word(32'hDEADBEEF);
        send(8'h22);
        idle(1);
        check("t6_good_done", done, 1);
        do_reload();
        send_word(32'd1);
        send_word(32'hDEADBEEF);
        send(8'h23);
        idle(1);
        check("t6_bad_err", err, 1);
        check("t6_bad_hold", cpu_hold, 1);
        check("t6_bad_written", wr_addr.size(), 1);
        do_reload();
        check("t6_recover_err", err, 0);
        check("t6_recover_ready", in_ready, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
